prbs_link_ctrl: RTL and testbench
=================================

PRBS_LINK_CTRL -- requirements
Module: prbs_link_ctrl

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 8: consecutive error-free words needed to declare lock.
REQ-002 SHALL have parameter UNLOCK_CNT, default 4: consecutive errored words in RUN that drop lock.
REQ-003 SHALL have parameter LOCK_TMO, default 1024: maximum received words spent in LOCK before the test fails.
REQ-004 SHALL have parameter ERR_W, default 16: error counter width.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port start, input, 1: single-cycle pulse that begins a test; ignored unless in IDLE or DONE.
REQ-008 SHALL have port abort, input, 1: returns the block to IDLE from any state.
REQ-009 SHALL have port test_len, input, 32: number of words to check in RUN; sampled on start.
REQ-010 SHALL have port rx_data, input, 32: received word; bit 0 is the earliest serial bit.
REQ-011 SHALL have port rx_valid, input, 1: rx_data is qualified this cycle.
REQ-012 SHALL have port gen_en, output, 1: enable for the 32-bit PRBS7 pattern generator.
REQ-013 SHALL have port busy, output, 1: high in FILL, LOCK or RUN.
REQ-014 SHALL have port locked, output, 1: high in RUN.
REQ-015 SHALL have port done, output, 1: high in DONE.
REQ-016 SHALL have port pass, output, 1: valid while done is high.
REQ-017 SHALL have port lost_lock, output, 1: sticky flag; set if lock was dropped during the current test.
REQ-018 SHALL have port err_cnt, output, ERR_W: saturating count of errored bits.
REQ-019 SHALL have port word_cnt, output, 32: number of words checked in RUN.

Function
REQ-020 SHALL check each valid word bitwise against PRBS7 recurrence s[n] = s[n-7] ^ s[n-6] in serial order.
REQ-021 SHALL take bits s[n-7..n-1] for word bits 0..6 from the previous valid word's bits 25..31.
REQ-022 SHALL treat the erroneous received bits as the history used to predict later bits (self-synchronising checker).
REQ-023 SHALL register the per-word error mask and its popcount (0..32), giving a 1-cycle check latency after rx_valid.
REQ-024 SHALL implement states IDLE, FILL, LOCK, RUN and DONE.
REQ-025 SHALL, in IDLE or DONE on start, clear err_cnt, word_cnt, lost_lock and the timeout counter, latch test_len, and go to FILL.
REQ-026 SHALL, in FILL, load history from the first valid word and then go to LOCK; this word is never checked.
REQ-027 SHALL, in LOCK, count consecutive error-free checked words; any errored word resets this count to 0.
REQ-028 SHALL go from LOCK to RUN when the consecutive error-free count reaches LOCK_CNT.
REQ-029 SHALL go from LOCK to DONE with pass=0 when LOCK_TMO words have been checked in LOCK without lock.
REQ-030 SHALL, in RUN, add each word's popcount to err_cnt, saturating at all-ones, and increment word_cnt per checked word.
REQ-031 SHALL, in RUN, go to LOCK and set lost_lock after UNLOCK_CNT consecutive errored words; word_cnt and err_cnt hold.
REQ-032 SHALL go from RUN to DONE when word_cnt reaches the latched test_len, with pass = (err_cnt==0 && !lost_lock).
REQ-033 SHALL, if test_len==0, go from LOCK directly to DONE on lock with pass=1.
REQ-034 SHALL assert gen_en in FILL, LOCK and RUN and deassert it otherwise.
REQ-035 SHALL give abort priority over start and over every other transition; abort clears nothing except state.
REQ-036 SHALL leave all counters unchanged on cycles where rx_valid=0.

Reset
REQ-037 SHALL, while rst_n=0, force state IDLE and drive all outputs 0, including err_cnt and word_cnt, and clear history and internal counters.
REQ-038 SHALL hold IDLE after rst_n deasserts until a start pulse arrives.

Structure
REQ-039 SHALL place the state encoding and the PRBS7 tap constants (7,6) in a shared package prbs_pkg.
REQ-040 SHALL implement the history, error-mask and popcount logic in sub-module prbs7_chk32.

Verification
REQ-041 SHALL cover a clean PRBS7 stream with test_len=1000: locked after 1+8 words, done at word 1000 with err_cnt=0 and pass=1.
REQ-042 SHALL cover one flipped bit in RUN: err_cnt=3, because the bit feeds two later predictions, and pass=0.
REQ-043 SHALL cover all-zero rx_data: it satisfies the recurrence, so lock is achieved; the bench flags this known PRBS7 limitation.
REQ-044 SHALL cover random data: done with pass=0 and locked never set, after 1024 words in LOCK.
REQ-045 SHALL cover 4 corrupted words in RUN: lost_lock=1 and return to LOCK, then relock after 8 clean words and finish with pass=0.
REQ-046 SHALL cover abort in RUN and rst_n low in RUN: both give IDLE with gen_en=0 on the next edge, and reset also gives all outputs 0.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS7 link checker: controller state encoding,
// PRBS7 tap positions and a popcount helper.
package prbs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_LOCK = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // s[n] = s[n-PRBS_TAP_A] ^ s[n-PRBS_TAP_B]
    localparam int PRBS_TAP_A = 7;
    localparam int PRBS_TAP_B = 6;
    localparam int HIST_W     = PRBS_TAP_A;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs7_chk32.sv
// Self-synchronising PRBS7 checker, 32 bits per word; one cycle from in_vld to chk_vld.
// No backpressure: every qualified word produces a result on the following cycle.
module prbs7_chk32
    import prbs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    input  logic        chk_en,
    input  logic [31:0] in_dat,
    output logic        chk_vld,
    output logic [31:0] err_mask,
    output logic [5:0]  err_pop
);

    logic [HIST_W-1:0]    hist_q, hist_d;
    logic [31:0]          mask_q, mask_d;
    logic [5:0]           pop_q, pop_d;
    logic                 vld_q, vld_d;
    logic [HIST_W+31:0]   ext;

    // ext[0..6] are the last seven bits of the previous word, oldest first;
    // received bits (right or wrong) become history for later predictions.
    always_comb begin
        ext    = {in_dat, hist_q};
        mask_d = '0;
        for (int i = 0; i < 32; i++) begin
            mask_d[i] = ext[HIST_W+i] ^ ext[HIST_W+i-PRBS_TAP_A] ^ ext[HIST_W+i-PRBS_TAP_B];
        end
        pop_d  = popcount32(mask_d);
        vld_d  = in_vld & chk_en;
        hist_d = in_vld ? in_dat[31:32-HIST_W] : hist_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            mask_q <= '0;
            pop_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            mask_q <= mask_d;
            pop_q  <= pop_d;
            vld_q  <= vld_d;
        end
    end

    assign chk_vld  = vld_q;
    assign err_mask = mask_q;
    assign err_pop  = pop_q;

endmodule

// File: rtl/prbs_link_ctrl.sv
// PRBS7 link test controller: fill history, acquire lock, count errors over test_len words.
// Results lag rx_valid by one cycle; rx_valid low simply stalls all counters.
module prbs_link_ctrl
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int LOCK_TMO   = 1024,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      test_len,
    input  logic [31:0]      rx_data,
    input  logic             rx_valid,
    output logic             gen_en,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             pass,
    output logic             lost_lock,
    output logic [ERR_W-1:0] err_cnt,
    output logic [31:0]      word_cnt
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam int TW = $clog2(LOCK_TMO + 1);
    localparam int SW = ERR_W + 6;

    state_t           state_q, state_d;
    logic [31:0]      tlen_q, tlen_d;
    logic [GW-1:0]    good_q, good_d, good_nxt;
    logic [BW-1:0]    bad_q, bad_d, bad_nxt;
    logic [TW-1:0]    tmo_q, tmo_d, tmo_nxt;
    logic [ERR_W-1:0] err_q, err_d, err_nxt;
    logic [31:0]      word_q, word_d, word_nxt;
    logic             lost_q, lost_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             locked_q, locked_d;
    logic             done_q, done_d;
    logic             gen_q, gen_d;
    logic [SW-1:0]    err_sum;

    logic             chk_ld, chk_en;
    logic             chk_vld;
    logic [31:0]      chk_mask;
    logic [5:0]       chk_pop;
    logic             word_bad;

    assign chk_ld = rx_valid && (state_q == ST_FILL || state_q == ST_LOCK || state_q == ST_RUN);
    assign chk_en = (state_q == ST_LOCK || state_q == ST_RUN);

    prbs7_chk32 u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (chk_ld),
        .chk_en   (chk_en),
        .in_dat   (rx_data),
        .chk_vld  (chk_vld),
        .err_mask (chk_mask),
        .err_pop  (chk_pop)
    );

    assign word_bad = |chk_mask;

    always_comb begin
        state_d  = state_q;
        tlen_d   = tlen_q;
        good_d   = good_q;
        bad_d    = bad_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        word_d   = word_q;
        lost_d   = lost_q;
        pass_d   = pass_q;

        good_nxt = word_bad ? '0 : good_q + GW'(1);
        bad_nxt  = word_bad ? bad_q + BW'(1) : '0;
        tmo_nxt  = tmo_q + TW'(1);
        word_nxt = word_q + 32'd1;
        err_sum  = SW'(err_q) + SW'(chk_pop);
        err_nxt  = (|err_sum[SW-1:ERR_W]) ? '1 : err_sum[ERR_W-1:0];

        // Abort only moves the state; every counter and flag keeps its value.
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_FILL;
                        tlen_d  = test_len;
                        good_d  = '0;
                        bad_d   = '0;
                        tmo_d   = '0;
                        err_d   = '0;
                        word_d  = '0;
                        lost_d  = 1'b0;
                        pass_d  = 1'b0;
                    end
                end
                ST_FILL: begin
                    if (rx_valid) begin
                        state_d = ST_LOCK;
                        good_d  = '0;
                    end
                end
                ST_LOCK: begin
                    if (chk_vld) begin
                        good_d = good_nxt;
                        tmo_d  = tmo_nxt;
                        if (good_nxt == GW'(LOCK_CNT)) begin
                            if (tlen_q == 32'd0) begin
                                state_d = ST_DONE;
                                pass_d  = 1'b1;
                            end else begin
                                state_d = ST_RUN;
                                bad_d   = '0;
                            end
                        end else if (tmo_nxt == TW'(LOCK_TMO)) begin
                            state_d = ST_DONE;
                            pass_d  = 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (chk_vld) begin
                        word_d = word_nxt;
                        err_d  = err_nxt;
                        bad_d  = bad_nxt;
                        if (word_nxt == tlen_q) begin
                            state_d = ST_DONE;
                            pass_d  = (err_nxt == '0) && !lost_q;
                        end else if (bad_nxt == BW'(UNLOCK_CNT)) begin
                            state_d = ST_LOCK;
                            lost_d  = 1'b1;
                            good_d  = '0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d   = (state_d == ST_FILL) || (state_d == ST_LOCK) || (state_d == ST_RUN);
        gen_d    = busy_d;
        locked_d = (state_d == ST_RUN);
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tlen_q   <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            tmo_q    <= '0;
            err_q    <= '0;
            word_q   <= '0;
            lost_q   <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
            gen_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tlen_q   <= tlen_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            word_q   <= word_d;
            lost_q   <= lost_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
            done_q   <= done_d;
            gen_q    <= gen_d;
        end
    end

    assign gen_en    = gen_q;
    assign busy      = busy_q;
    assign locked    = locked_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign lost_lock = lost_q;
    assign err_cnt   = err_q;
    assign word_cnt  = word_q;

endmodule

// File: tb/tb_prbs_link_ctrl.sv
// Directed bench for prbs_link_ctrl with a serial PRBS7 reference generator.
module tb_prbs_link_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] test_len;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        gen_en;
    logic        busy;
    logic        locked;
    logic        done;
    logic        pass;
    logic        lost_lock;
    logic [15:0] err_cnt;
    logic [31:0] word_cnt;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [6:0]  gs;
    logic        ever_locked;

    always #5 clk = ~clk;

    prbs_link_ctrl #(
        .LOCK_CNT   (8),
        .UNLOCK_CNT (4),
        .LOCK_TMO   (1024),
        .ERR_W      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .test_len  (test_len),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .gen_en    (gen_en),
        .busy      (busy),
        .locked    (locked),
        .done      (done),
        .pass      (pass),
        .lost_lock (lost_lock),
        .err_cnt   (err_cnt),
        .word_cnt  (word_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial PRBS7: gs[0] is s[n-7], gs[6] is s[n-1]; word bit 0 is earliest.
    task automatic next_word(output logic [31:0] w);
        logic b;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            b    = gs[0] ^ gs[1];
            w[i] = b;
            gs   = {b, gs[6:1]};
        end
    endtask

    task automatic send(input logic [31:0] xm);
        logic [31:0] w;
        next_word(w);
        rx_valid = 1'b1;
        rx_data  = w ^ xm;
        tick();
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) send(32'h0);
    endtask

    task automatic send_raw(input logic [31:0] w);
        rx_valid = 1'b1;
        rx_data  = w;
        tick();
    endtask

    task automatic idle();
        rx_valid = 1'b0;
        rx_data  = '0;
        tick();
    endtask

    task automatic begin_test(input logic [31:0] len);
        rx_valid = 1'b0;
        test_len = len;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // FILL word plus LOCK_CNT clean words, then one idle cycle to drain the check pipeline.
    task automatic lock_up();
        send_n(9);
        idle();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        test_len = '0;
        rx_data  = '0;
        rx_valid = 1'b0;
        gs       = 7'h01;
        ever_locked = 1'b0;

        tick();
        tick();
        chk("rst_flags", 64'({gen_en, busy, locked, done, pass, lost_lock}), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("idle_hold_busy", 64'(busy), 64'd0);
        chk("idle_hold_gen_en", 64'(gen_en), 64'd0);

        // Clean stream, 1000 words.
        begin_test(32'd1000);
        chk("fill_busy", 64'(busy), 64'd1);
        chk("fill_gen_en", 64'(gen_en), 64'd1);
        send_n(9);
        chk("clean_not_locked_yet", 64'(locked), 64'd0);
        idle();
        chk("clean_locked", 64'(locked), 64'd1);
        chk("clean_word_cnt_at_lock", 64'(word_cnt), 64'd0);
        send_n(999);
        chk("clean_word_cnt_998", 64'(word_cnt), 64'd998);
        send_n(1);
        chk("clean_word_cnt_999", 64'(word_cnt), 64'd999);
        chk("clean_not_done_999", 64'(done), 64'd0);
        idle();
        chk("clean_done", 64'(done), 64'd1);
        chk("clean_pass", 64'(pass), 64'd1);
        chk("clean_err_cnt", 64'(err_cnt), 64'd0);
        chk("clean_word_cnt", 64'(word_cnt), 64'd1000);
        chk("clean_busy_off", 64'({busy, gen_en, locked}), 64'd0);

        // Single flipped bit: errors at bits 3, 9 and 10.
        begin_test(32'd20);
        lock_up();
        chk("flip_locked", 64'(locked), 64'd1);
        send_n(5);
        send(32'h0000_0008);
        send_n(1);
        chk("flip_err_cnt_mid", 64'(err_cnt), 64'd3);
        send_n(13);
        idle();
        chk("flip_done", 64'(done), 64'd1);
        chk("flip_err_cnt", 64'(err_cnt), 64'd3);
        chk("flip_pass", 64'(pass), 64'd0);
        chk("flip_word_cnt", 64'(word_cnt), 64'd20);
        chk("flip_lost_lock", 64'(lost_lock), 64'd0);

        // All-zero data satisfies the recurrence, so the checker locks on it.
        begin_test(32'd16);
        for (int i = 0; i < 9; i++) send_raw(32'h0);
        idle();
        chk("zero_locked", 64'(locked), 64'd1);
        $display("note: all-zero rx_data locks the PRBS7 checker (known limitation)");
        for (int i = 0; i < 16; i++) send_raw(32'h0);
        idle();
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_pass", 64'(pass), 64'd1);

        // Random data: lock timeout after 1024 checked words.
        begin_test(32'd100);
        for (int i = 0; i < 1024; i++) begin
            send_raw($urandom());
            if (locked) ever_locked = 1'b1;
        end
        idle();
        chk("rand_not_done_1023", 64'(done), 64'd0);
        send_raw($urandom());
        idle();
        chk("rand_done", 64'(done), 64'd1);
        chk("rand_pass", 64'(pass), 64'd0);
        chk("rand_never_locked", 64'(ever_locked), 64'd0);

        // Four consecutive errored words in RUN drop lock; relock then finish.
        begin_test(32'd30);
        lock_up();
        send_n(5);
        for (int i = 0; i < 4; i++) send(32'h0000_0001);
        idle();
        chk("unlock_locked", 64'(locked), 64'd0);
        chk("unlock_lost_lock", 64'(lost_lock), 64'd1);
        chk("unlock_busy", 64'(busy), 64'd1);
        chk("unlock_word_cnt", 64'(word_cnt), 64'd9);
        chk("unlock_err_cnt", 64'(err_cnt), 64'd12);
        send_n(8);
        idle();
        chk("relock_locked", 64'(locked), 64'd1);
        send_n(21);
        idle();
        chk("unlock_done", 64'(done), 64'd1);
        chk("unlock_pass", 64'(pass), 64'd0);
        chk("unlock_word_cnt_end", 64'(word_cnt), 64'd30);
        chk("unlock_err_cnt_end", 64'(err_cnt), 64'd12);

        // test_len == 0: straight from LOCK to DONE.
        begin_test(32'd0);
        lock_up();
        chk("len0_done", 64'(done), 64'd1);
        chk("len0_pass", 64'(pass), 64'd1);
        chk("len0_never_run", 64'(locked), 64'd0);

        // Abort in RUN; a start pulse while busy is ignored.
        begin_test(32'd100);
        lock_up();
        start = 1'b1;
        send(32'h0);
        start = 1'b0;
        chk("start_ignored_in_run", 64'({busy, locked}), 64'd3);
        rx_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 64'({busy, locked, done, gen_en}), 64'd0);

        // Reset asserted in RUN.
        begin_test(32'd100);
        lock_up();
        send_n(3);
        chk("prerst_word_cnt", 64'(word_cnt), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("rst_run_flags", 64'({gen_en, busy, locked, done, pass, lost_lock}), 64'd0);
        chk("rst_run_counts", 64'({err_cnt, word_cnt}), 64'd0);
        rx_valid = 1'b0;
        tick();
        chk("rst_run_hold", 64'({gen_en, busy}), 64'd0);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
